// File: rtl/pipe_pkg.sv
// Shared pipeline types: widths, ID/EX state encoding and
// the control bundle passed from ID/EX to EX/WB.
package pipe_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int ALUOP_W = 4;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_HOLD       = 2'd1;
  localparam logic [1:0] ST_FLUSH_PEND = 2'd2;

  typedef enum logic [1:0] {
    RUN        = ST_RUN,
    HOLD       = ST_HOLD,
    FLUSH_PEND = ST_FLUSH_PEND
  } idex_state_t;

  typedef struct packed {
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-ID/EX handshake bundle.
// Decode is the master; the ID/EX register is the slave.
interface id_ex_stage_if
  import pipe_pkg::*;
();

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  ctrl_t             ctrl;

  modport master (
    output valid, rs_addr, rt_addr,
    output write_addr, rs_data,
    output rt_data, imm, ctrl,
    input  ready
  );

  modport slave (
    input  valid, rs_addr, rt_addr,
    input  write_addr, rs_data,
    input  rt_data, imm, ctrl,
    output ready
  );

endinterface

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating up-counter with synchronous
// active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold, flush
// (including flush-during-hold) and bubble count.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  id_ex_stage_if.slave       id,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic               em_valid_o,
  output logic [ADDR_W-1:0]  em_rs_addr_o,
  output logic [ADDR_W-1:0]  em_rt_addr_o,
  output logic [ADDR_W-1:0]  em_write_addr_o,
  output logic [DATA_W-1:0]  em_rs_data_o,
  output logic [DATA_W-1:0]  em_rt_data_o,
  output logic [DATA_W-1:0]  em_imm_o,
  output logic               em_memread_o,
  output logic               em_memwrite_o,
  output logic               em_regwrite_o,
  output logic [ALUOP_W-1:0] em_aluop_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  idex_state_t state_q;
  idex_state_t state_d;
  ctrl_t       ctrl_q;
  logic        pend;
  logic        load;
  logic        bubble;

  assign id.ready = !hold_i;
  assign pend     = flush_i || (state_q == FLUSH_PEND);
  assign load     = !hold_i;
  assign bubble   = load && (pend || !id.valid);

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      !hold_i:        state_d = RUN;
      hold_i && pend: state_d = FLUSH_PEND;
      default:        state_d = HOLD;
    endcase
  end

  // Bubbles clear every field so forwarding never
  // matches a stale address.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= RUN;
      em_valid_o      <= 1'b0;
      em_rs_addr_o    <= '0;
      em_rt_addr_o    <= '0;
      em_write_addr_o <= '0;
      em_rs_data_o    <= '0;
      em_rt_data_o    <= '0;
      em_imm_o        <= '0;
      ctrl_q          <= CTRL_NOP;
    end else begin
      state_q <= state_d;
      if (bubble) begin
        em_valid_o      <= 1'b0;
        em_rs_addr_o    <= '0;
        em_rt_addr_o    <= '0;
        em_write_addr_o <= '0;
        em_rs_data_o    <= '0;
        em_rt_data_o    <= '0;
        em_imm_o        <= '0;
        ctrl_q          <= CTRL_NOP;
      end else if (load) begin
        em_valid_o      <= 1'b1;
        em_rs_addr_o    <= id.rs_addr;
        em_rt_addr_o    <= id.rt_addr;
        em_write_addr_o <= id.write_addr;
        em_rs_data_o    <= id.rs_data;
        em_rt_data_o    <= id.rt_data;
        em_imm_o        <= id.imm;
        ctrl_q          <= id.ctrl;
      end
    end
  end

  assign em_memread_o  = ctrl_q.memread;
  assign em_memwrite_o = ctrl_q.memwrite;
  assign em_regwrite_o = ctrl_q.regwrite;
  assign em_aluop_o    = ctrl_q.aluop;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (bubble),
    .cnt_o   (bubble_cnt_o)
  );

endmodule
